// File: rtl/rv16_fetch_unit.sv
// Instruction fetch front end: word-aligned fetch address generation, req/gnt/rvalid
// memory handshake, in-order fetch FIFO and redirect handling with response kill.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | issuing fetches whenever FIFO space covers every in-flight word
// ST_HALT | a bus error was returned; no requests until the next redirect
module rv16_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_err,
   output logic [31:0] o_fetch_data,
   output logic        o_fetch_valid,
   output logic [31:0] o_pc,
   output logic        o_fetch_err
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   // kill can exceed FIFO_DEPTH when redirects arrive back-to-back; one extra bit of headroom
   localparam int unsigned KW = CW + 1;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          armed_q, armed_d;
   logic [29:0]   fetch_addr_q, fetch_addr_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [KW-1:0] kill_q, kill_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;

   logic [31:0] fifo_data_q [FIFO_DEPTH];
   logic [31:0] fifo_data_d [FIFO_DEPTH];
   logic [31:0] fifo_pc_q   [FIFO_DEPTH];
   logic [31:0] fifo_pc_d   [FIFO_DEPTH];
   logic        fifo_err_q  [FIFO_DEPTH];
   logic        fifo_err_d  [FIFO_DEPTH];

   logic [CW:0]   occupancy;
   logic [KW-1:0] in_flight;
   logic          issue;
   logic          handshake;
   logic          resp_killed;
   logic          resp_live;
   logic          push;
   logic          pop;

   always_comb begin
      occupancy   = {1'b0, count_q} + {1'b0, outstanding_q};
      issue       = (state_q == ST_RUN) && armed_q && (occupancy < DEPTH_C);
      handshake   = issue && i_mem_gnt;
      resp_killed = i_mem_rvalid && (kill_q != '0);
      resp_live   = i_mem_rvalid && (kill_q == '0);
      push        = resp_live && (state_q == ST_RUN) && !i_redirect;
      pop         = (count_q != '0) && !i_stall && !i_redirect;
      // every in-flight response after this cycle, whether killed or not, becomes a kill
      in_flight   = kill_q + KW'(outstanding_q) + KW'(handshake) - KW'(i_mem_rvalid);
   end

   always_comb begin
      state_d       = state_q;
      armed_d       = 1'b1;
      fetch_addr_d  = fetch_addr_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      kill_d        = kill_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      fifo_data_d   = fifo_data_q;
      fifo_pc_d     = fifo_pc_q;
      fifo_err_d    = fifo_err_q;

      if (i_redirect) begin
         state_d       = ST_RUN;
         fetch_addr_d  = i_redirect_pc[31:2];
         resp_pc_d     = i_redirect_pc & ~32'd1;
         outstanding_d = '0;
         kill_d        = in_flight;
         count_d       = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
      end else begin
         if (handshake) begin
            fetch_addr_d = fetch_addr_q + 30'd1;
         end
         outstanding_d = outstanding_q + CW'(handshake) - CW'(resp_live);
         kill_d        = kill_q - KW'(resp_killed);

         if (resp_live) begin
            resp_pc_d = {resp_pc_q[31:2] + 30'd1, 2'b00};
            if (i_mem_err && (state_q == ST_RUN)) begin
               state_d = ST_HALT;
            end
         end

         if (push) begin
            fifo_data_d[wr_ptr_q] = i_mem_err ? 32'h0 : i_mem_rdata;
            fifo_pc_d[wr_ptr_q]   = resp_pc_q;
            fifo_err_d[wr_ptr_q]  = i_mem_err;
            wr_ptr_d              = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         armed_q       <= 1'b0;
         fetch_addr_q  <= RESET_PC[31:2];
         resp_pc_q     <= RESET_PC & ~32'd1;
         outstanding_q <= '0;
         kill_q        <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         armed_q       <= armed_d;
         fetch_addr_q  <= fetch_addr_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         kill_q        <= kill_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_err_q  <= fifo_err_d;
   end

   assign o_mem_req     = issue;
   assign o_mem_addr    = {fetch_addr_q, 2'b00};
   assign o_fetch_valid = (count_q != '0);
   assign o_fetch_data  = o_fetch_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
   assign o_pc          = o_fetch_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
   assign o_fetch_err   = o_fetch_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count_q == FULL_C)));

   a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_mem_rvalid && (kill_q == '0) && (outstanding_q == '0)));

endmodule
